// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: queues (message, output) address jobs and hands them
// round-robin to an array of simplified_sha256 engines over start/done.
module sha256_job_scheduler #(
  parameter int unsigned NUM_ENG    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [15:0]                     job_msg_addr,
  input  logic [15:0]                     job_out_addr,
  output logic [NUM_ENG-1:0]              eng_start,
  output logic [NUM_ENG*16-1:0]           eng_msg_addr,
  output logic [NUM_ENG*16-1:0]           eng_out_addr,
  input  logic [NUM_ENG-1:0]              eng_done,
  output logic [NUM_ENG-1:0]              cmp_mask,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [NUM_ENG-1:0]              busy_mask,
  output logic                            idle,
  output logic                            err_nostart
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = $clog2(NUM_ENG);

  // START1: the cycle eng_start is high (done is still 1 there).
  // START2: second cycle after start; done must have dropped by now.
  typedef enum logic [1:0] {
    ENG_FREE   = 2'd0,
    ENG_START1 = 2'd1,
    ENG_START2 = 2'd2,
    ENG_RUN    = 2'd3
  } eng_state_e;

  // Job queue storage and pointers
  logic [15:0]       fifo_msg_q [FIFO_DEPTH];
  logic [15:0]       fifo_out_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  // Engine tracking
  eng_state_e        state_q [NUM_ENG];
  eng_state_e        state_d [NUM_ENG];
  logic [NUM_ENG-1:0] free_vec;
  logic [NUM_ENG-1:0] nostart;
  logic [EW-1:0]     rr_q, rr_d;
  logic [EW-1:0]     sel;
  logic [EW-1:0]     cand;
  logic              found;
  logic              dispatch;

  // Registered outputs
  logic [NUM_ENG-1:0]    start_q, start_d;
  logic [NUM_ENG*16-1:0] msg_q, msg_d;
  logic [NUM_ENG*16-1:0] out_q, out_d;
  logic                  err_q, err_d;

  assign job_ready    = (count_q != CW'(FIFO_DEPTH));
  assign push         = job_valid && job_ready;
  assign pop          = dispatch;
  assign fifo_level   = count_q;
  assign eng_start    = start_q;
  assign eng_msg_addr = msg_q;
  assign eng_out_addr = out_q;
  assign err_nostart  = err_q;
  assign busy_mask    = ~free_vec;
  assign idle         = (count_q == '0) && (busy_mask == '0);

  // Free-engine vector from the per-engine state
  always_comb begin
    free_vec = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      free_vec[i] = (state_q[i] == ENG_FREE);
    end
  end

  // Round-robin pick: first free engine at or after rr pointer, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_ENG; k++) begin
      cand = EW'((32'(rr_q) + k) % NUM_ENG);
      if (!found && free_vec[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign dispatch = (count_q != '0) && found;

  // Queue pointer/level and dispatch-side next-state values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    start_d  = '0;
    msg_d    = msg_q;
    out_d    = out_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (dispatch) begin
      start_d[sel]         = 1'b1;
      msg_d[sel*16 +: 16]  = fifo_msg_q[rd_ptr_q];
      out_d[sel*16 +: 16]  = fifo_out_q[rd_ptr_q];
      rr_d = (sel == EW'(NUM_ENG - 1)) ? '0 : sel + EW'(1);
    end
  end

  // Per-engine next state, completion pulses and no-start detection
  always_comb begin
    cmp_mask = '0;
    nostart  = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ENG_FREE: begin
          if (dispatch && (sel == EW'(i))) state_d[i] = ENG_START1;
        end
        ENG_START1: begin
          state_d[i] = eng_done[i] ? ENG_START2 : ENG_RUN;
        end
        ENG_START2: begin
          if (eng_done[i]) begin
            state_d[i] = ENG_FREE;
            nostart[i] = 1'b1;
          end else begin
            state_d[i] = ENG_RUN;
          end
        end
        ENG_RUN: begin
          if (eng_done[i]) begin
            state_d[i]  = ENG_FREE;
            cmp_mask[i] = 1'b1;
          end
        end
        default: state_d[i] = ENG_FREE;
      endcase
    end
  end

  assign err_d = err_q | (|nostart);

  // Queue payload storage; no reset needed, validity comes from the level
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_msg_q[wr_ptr_q] <= job_msg_addr;
      fifo_out_q[wr_ptr_q] <= job_out_addr;
    end
  end

  // Control/state registers with async active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      start_q  <= '0;
      msg_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= ENG_FREE;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      start_q  <= start_d;
      msg_q    <= msg_d;
      out_q    <= out_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: directed scenarios plus a random soak,
// checked every cycle against a queue-based reference model.
module tb_sha256_job_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              job_valid;
  logic              job_ready;
  logic [15:0]       job_msg_addr;
  logic [15:0]       job_out_addr;
  logic [N-1:0]      eng_start;
  logic [N*16-1:0]   eng_msg_addr;
  logic [N*16-1:0]   eng_out_addr;
  logic [N-1:0]      eng_done;
  logic [N-1:0]      cmp_mask;
  logic [$clog2(D):0] fifo_level;
  logic [N-1:0]      busy_mask;
  logic              idle;
  logic              err_nostart;

  always #5 clk = ~clk;

  sha256_job_scheduler #(.NUM_ENG(N), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_msg_addr (job_msg_addr),
    .job_out_addr (job_out_addr),
    .eng_start    (eng_start),
    .eng_msg_addr (eng_msg_addr),
    .eng_out_addr (eng_out_addr),
    .eng_done     (eng_done),
    .cmp_mask     (cmp_mask),
    .fifo_level   (fifo_level),
    .busy_mask    (busy_mask),
    .idle         (idle),
    .err_nostart  (err_nostart)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending jobs as a queue, engines as busy/ran/age
  logic [31:0] jobq[$];
  bit          m_busy [N];
  bit          m_ran  [N];
  int          m_age  [N];
  logic [15:0] m_msg  [N];
  logic [15:0] m_out  [N];
  logic [N-1:0] m_start;
  int          m_rr;
  bit          m_err;

  // Engine environment: remaining busy cycles, run length, ignore-start
  int          env_rem [N];
  int          env_L   [N];
  bit          env_ign [N];

  logic [N-1:0] last_start;
  logic [N-1:0] start_log[$];
  logic [N-1:0] cmp_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    jobq.delete();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_ran[i] = 0; m_age[i] = 0;
      m_msg[i] = '0; m_out[i] = '0;
    end
    m_start = '0;
    m_rr    = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] ma, input logic [15:0] oa,
                            input logic [N-1:0] dn);
    bit ob [N];
    int sz;
    int pick;
    logic [31:0] j;
    ob = m_busy;
    sz = jobq.size();
    m_start = '0;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        if (!m_ran[i]) begin
          if (!dn[i]) m_ran[i] = 1;
          else if (m_age[i] == 1) begin m_busy[i] = 0; m_err = 1; end
          else m_age[i] = 1;
        end else if (dn[i]) begin
          m_busy[i] = 0;
        end
      end
    end
    pick = -1;
    if (sz > 0) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && !ob[(m_rr + k) % N]) pick = (m_rr + k) % N;
      end
    end
    if (pick >= 0) begin
      j = jobq.pop_front();
      m_msg[pick] = j[31:16];
      m_out[pick] = j[15:0];
      m_start[pick] = 1'b1;
      m_busy[pick] = 1; m_ran[pick] = 0; m_age[pick] = 0;
      m_rr = (pick + 1) % N;
    end
    if (v && sz < D) jobq.push_back({ma, oa});
  endtask

  task automatic env_step(input logic [N-1:0] st, input logic [N-1:0] dn);
    for (int i = 0; i < N; i++) begin
      if (env_rem[i] > 0) env_rem[i]--;
      if (st[i] && dn[i] && !env_ign[i]) env_rem[i] = env_L[i];
    end
  endtask

  // One clock: drive at negedge, compare against model, step both at posedge
  task automatic cycle(input bit v, input logic [15:0] ma, input logic [15:0] oa);
    logic [N-1:0]   dn;
    logic [N-1:0]   e_busy;
    logic [N-1:0]   e_cmp;
    logic [N*16-1:0] e_msg;
    logic [N*16-1:0] e_out;
    @(negedge clk);
    job_valid = v; job_msg_addr = ma; job_out_addr = oa;
    for (int i = 0; i < N; i++) dn[i] = (env_rem[i] == 0);
    eng_done = dn;
    #1;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = m_busy[i];
      e_cmp[i]  = m_busy[i] && m_ran[i] && dn[i];
      e_msg[16*i +: 16] = m_msg[i];
      e_out[16*i +: 16] = m_out[i];
    end
    chk("job_ready",    64'(job_ready),    64'(jobq.size() < D));
    chk("fifo_level",   64'(fifo_level),   64'(jobq.size()));
    chk("eng_start",    64'(eng_start),    64'(m_start));
    chk("eng_msg_addr", 64'(eng_msg_addr), 64'(e_msg));
    chk("eng_out_addr", 64'(eng_out_addr), 64'(e_out));
    chk("cmp_mask",     64'(cmp_mask),     64'(e_cmp));
    chk("busy_mask",    64'(busy_mask),    64'(e_busy));
    chk("idle",         64'(idle),         64'(jobq.size() == 0 && e_busy == '0));
    chk("err_nostart",  64'(err_nostart),  64'(m_err));
    last_start = eng_start;
    if (eng_start != '0) start_log.push_back(eng_start);
    if (cmp_mask != '0)  cmp_log.push_back(cmp_mask);
    @(posedge clk);
    model_step(v, ma, oa, dn);
    env_step(last_start, dn);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    job_valid = 1'b0;
    eng_done = '1;
    for (int i = 0; i < N; i++) begin env_rem[i] = 0; env_ign[i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_log.delete();
    cmp_log.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 16'h0, 16'h0);
  endtask

  task automatic push_random(input int n);
    for (int c = 0; c < n; c++) cycle(1'b1, 16'($urandom), 16'($urandom));
  endtask

  // Shorten all running engines and let the queue empty out
  task automatic drain();
    for (int i = 0; i < N; i++) begin
      env_L[i] = 2;
      if (env_rem[i] > 1) env_rem[i] = 1;
    end
    idle_cycles(30);
    chk("drain_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    job_valid = 1'b0;
    job_msg_addr = '0;
    job_out_addr = '0;
    eng_done = '1;
    for (int i = 0; i < N; i++) env_L[i] = 3;

    // Reset values and single job through engine 0
    do_reset();
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ready", 64'(job_ready), 64'd1);
    cycle(1'b1, 16'h0000, 16'h0100);
    idle_cycles(2);
    chk("t1_start", 64'(last_start), 64'h1);
    chk("t1_msg0", 64'(eng_msg_addr[15:0]), 64'h0000);
    chk("t1_out0", 64'(eng_out_addr[15:0]), 64'h0100);
    idle_cycles(8);
    chk("t1_cmp_count", 64'(cmp_log.size()), 64'd1);
    if (cmp_log.size() > 0) chk("t1_cmp", 64'(cmp_log[0]), 64'h1);
    chk("t1_idle", 64'(idle), 64'd1);

    // Back-to-back offers with engines held busy: queue fills to 4
    do_reset();
    for (int i = 0; i < N; i++) env_L[i] = 60;
    push_random(10);
    chk("t2_ready", 64'(job_ready), 64'd0);
    chk("t2_level", 64'(fifo_level), 64'd4);
    chk("t2_nstart", 64'(start_log.size()), 64'd4);
    while (start_log.size() < 4) start_log.push_back('0);
    chk("t2_start0", 64'(start_log[0]), 64'h1);
    chk("t2_start1", 64'(start_log[1]), 64'h2);
    chk("t2_start2", 64'(start_log[2]), 64'h4);
    chk("t2_start3", 64'(start_log[3]), 64'h8);
    drain();

    // Round-robin: engines 1 and 3 free, rr=2 -> 3 then 1
    do_reset();
    env_L[0] = 40; env_L[1] = 2; env_L[2] = 40; env_L[3] = 2;
    push_random(4);
    idle_cycles(10);
    push_random(1);
    idle_cycles(10);
    start_log.delete();
    env_L[1] = 40; env_L[3] = 40;
    push_random(2);
    idle_cycles(4);
    chk("t3_nstart", 64'(start_log.size()), 64'd2);
    while (start_log.size() < 2) start_log.push_back('0);
    chk("t3_first", 64'(start_log[0]), 64'h8);
    chk("t3_second", 64'(start_log[1]), 64'h2);
    drain();

    // Simultaneous completion on engines 0 and 2 with two jobs waiting
    do_reset();
    for (int i = 0; i < N; i++) env_L[i] = 40;
    push_random(6);
    idle_cycles(2);
    start_log.delete();
    cmp_log.delete();
    env_rem[0] = 2;
    env_rem[2] = 2;
    idle_cycles(6);
    chk("t4_ncmp", 64'(cmp_log.size()), 64'd1);
    if (cmp_log.size() > 0) chk("t4_cmp", 64'(cmp_log[0]), 64'h5);
    chk("t4_nstart", 64'(start_log.size()), 64'd2);
    while (start_log.size() < 2) start_log.push_back('0);
    chk("t4_first", 64'(start_log[0]), 64'h1);
    chk("t4_second", 64'(start_log[1]), 64'h4);
    drain();

    // Engine 0 ignores start: sticky error, engine freed, no retry
    do_reset();
    for (int i = 0; i < N; i++) env_L[i] = 3;
    env_ign[0] = 1;
    push_random(1);
    idle_cycles(6);
    chk("t5_err", 64'(err_nostart), 64'd1);
    chk("t5_busy", 64'(busy_mask), 64'd0);
    chk("t5_ncmp", 64'(cmp_log.size()), 64'd0);
    env_ign[0] = 0;
    start_log.delete();
    push_random(1);
    idle_cycles(8);
    chk("t5_nstart", 64'(start_log.size()), 64'd1);
    if (start_log.size() > 0) chk("t5_next_eng", 64'(start_log[0]), 64'h2);
    chk("t5_err_sticky", 64'(err_nostart), 64'd1);

    // Async reset with jobs queued and in flight
    do_reset();
    for (int i = 0; i < N; i++) env_L[i] = 40;
    push_random(7);
    idle_cycles(1);
    chk("t6_pre_level", 64'(fifo_level), 64'd3);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_start", 64'(eng_start), 64'd0);
    chk("t6_cmp", 64'(cmp_mask), 64'd0);
    chk("t6_busy", 64'(busy_mask), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_idle", 64'(idle), 64'd1);
    chk("t6_ready", 64'(job_ready), 64'd1);
    chk("t6_err", 64'(err_nostart), 64'd0);
    chk("t6_msg", 64'(eng_msg_addr), 64'd0);
    chk("t6_out", 64'(eng_out_addr), 64'd0);
    for (int i = 0; i < N; i++) env_rem[i] = 0;
    eng_done = '1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_log.delete();
    cmp_log.delete();
    idle_cycles(10);
    chk("t6_post_nstart", 64'(start_log.size()), 64'd0);
    chk("t6_post_ncmp", 64'(cmp_log.size()), 64'd0);

    // Random soak
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        env_L[i]   = $urandom_range(1, 8);
        env_ign[i] = ($urandom_range(0, 19) == 0);
      end
      cycle($urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < N; i++) env_ign[i] = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
